// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the staged reset sequencer.
package reset_seq_pkg;

    typedef enum logic [2:0] {RESET, HOLD, STAGE, RUN, SOFT} seq_state_t;

    localparam int RELEASE_COUNT_W = 8;

    // Down-counter width able to hold the larger of the two reload periods.
    function automatic int cnt_width(input int hold_cycles, input int stage_gap);
        int longest;
        longest = (hold_cycles > stage_gap) ? hold_cycles : stage_gap;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/reset_sync.sv
// Async-assert / sync-release reset synchronizer, SYNC_STAGES flops deep.
module reset_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_l,
    output logic rst_sync
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rst_sync = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Staged active-low reset generator: synchronized release, hold period,
// in-order domain release, and soft re-reset via req/ack handshake.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 4,
    parameter int NUM_DOMAINS = 3,
    parameter int STAGE_GAP   = 2
) (
    input  logic                       clk,
    input  logic                       reset_l,
    input  logic                       soft_req,
    output logic                       soft_ack,
    output logic [NUM_DOMAINS-1:0]     sub_reset_l,
    output logic                       ready,
    output logic [RELEASE_COUNT_W-1:0] release_count
);

    localparam int CNT_W = cnt_width(HOLD_CYCLES, STAGE_GAP);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(STAGE_GAP - 1);
    localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DOMAINS - 1);
    localparam logic [NUM_DOMAINS-1:0] DOM_LSB = NUM_DOMAINS'(1);

    seq_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] dom_idx;
    logic             soft_pending;
    logic             rst_sync;

    reset_sync #(.SYNC_STAGES(SYNC_STAGES)) u_reset_sync (
        .clk      (clk),
        .reset_l  (reset_l),
        .rst_sync (rst_sync)
    );

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state         <= RESET;
            cnt           <= '0;
            dom_idx       <= '0;
            soft_pending  <= 1'b0;
            sub_reset_l   <= '0;
            ready         <= 1'b0;
            soft_ack      <= 1'b0;
            release_count <= '0;
        end else begin
            case (state)
                RESET: begin
                    if (rst_sync) begin
                        state <= HOLD;
                        cnt   <= HOLD_LOAD;
                    end
                end
                HOLD, SOFT: begin
                    if (cnt == '0) begin
                        state       <= STAGE;
                        sub_reset_l <= DOM_LSB;
                        dom_idx     <= '0;
                        cnt         <= GAP_LOAD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                STAGE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (dom_idx == LAST_IDX) begin
                        state        <= RUN;
                        ready        <= 1'b1;
                        soft_ack     <= soft_pending;
                        soft_pending <= 1'b0;
                        if (release_count != '1) begin
                            release_count <= release_count + 1'b1;
                        end
                    end else begin
                        dom_idx     <= dom_idx + 1'b1;
                        sub_reset_l <= (sub_reset_l << 1) | DOM_LSB;
                        cnt         <= GAP_LOAD;
                    end
                end
                RUN: begin
                    // The ack cycle itself never samples soft_req.
                    if (soft_ack) begin
                        soft_ack <= 1'b0;
                    end else if (soft_req) begin
                        state        <= SOFT;
                        sub_reset_l  <= '0;
                        ready        <= 1'b0;
                        soft_pending <= 1'b1;
                        cnt          <= HOLD_LOAD;
                    end
                end
                default: state <= RESET;
            endcase
        end
    end

    a_thermometer: assert property (@(posedge clk) disable iff (!reset_l)
        ((sub_reset_l & (sub_reset_l + DOM_LSB)) == '0));
    a_ready_all_released: assert property (@(posedge clk) disable iff (!reset_l)
        ready |-> (&sub_reset_l));
    a_ack_implies_ready: assert property (@(posedge clk) disable iff (!reset_l)
        soft_ack |-> ready);

    c_run_entered: cover property (@(posedge clk) disable iff (!reset_l) state == RUN);
    c_soft_done:   cover property (@(posedge clk) disable iff (!reset_l) soft_ack);
    c_count_sat:   cover property (@(posedge clk) disable iff (!reset_l) release_count == '1);

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed self-checking bench for reset_sequencer (default and minimal configs).
module tb_reset_sequencer;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_l, soft_req, soft_ack, ready;
    logic [2:0] sub;
    logic [7:0] cnt;

    logic       reset_l1, soft_req1, soft_ack1, ready1;
    logic [0:0] sub1;
    logic [7:0] cnt1;

    int checks = 0;
    int errors = 0;

    reset_sequencer u_dut (
        .clk           (clk),
        .reset_l       (reset_l),
        .soft_req      (soft_req),
        .soft_ack      (soft_ack),
        .sub_reset_l   (sub),
        .ready         (ready),
        .release_count (cnt)
    );

    reset_sequencer #(
        .SYNC_STAGES (2),
        .HOLD_CYCLES (1),
        .NUM_DOMAINS (1),
        .STAGE_GAP   (1)
    ) u_dut_min (
        .clk           (clk),
        .reset_l       (reset_l1),
        .soft_req      (soft_req1),
        .soft_ack      (soft_ack1),
        .sub_reset_l   (sub1),
        .ready         (ready1),
        .release_count (cnt1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Power-on, default params: domains at E7/E9/E11, ready at E13.
    function automatic logic [31:0] po_sub(input int k);
        if (k >= 11) return 32'd7;
        if (k >= 9)  return 32'd3;
        if (k >= 7)  return 32'd1;
        return 32'd0;
    endfunction

    // Soft sequence relative to Es (j=0); j=12 is the restart when req stays high.
    function automatic logic [31:0] soft_sub(input int j);
        if (j >= 12) return 32'd0;
        if (j >= 8)  return 32'd7;
        if (j >= 6)  return 32'd3;
        if (j >= 4)  return 32'd1;
        return 32'd0;
    endfunction

    task automatic power_on_check(input string tag, input int last_k);
        for (int k = 1; k <= last_k; k++) begin
            @(posedge clk); #1;
            check($sformatf("%s_sub_E%0d", tag, k), 32'(sub), po_sub(k));
            check($sformatf("%s_ready_E%0d", tag, k), 32'(ready), (k >= 13) ? 32'd1 : 32'd0);
            check($sformatf("%s_cnt_E%0d", tag, k), 32'(cnt), (k >= 13) ? 32'd1 : 32'd0);
            check($sformatf("%s_ack_E%0d", tag, k), 32'(soft_ack), 32'd0);
        end
    endtask

    task automatic soft_check(input string tag, input int first_j, input int last_j, input int base_cnt);
        for (int j = first_j; j <= last_j; j++) begin
            @(posedge clk); #1;
            check($sformatf("%s_sub_Es+%0d", tag, j), 32'(sub), soft_sub(j));
            check($sformatf("%s_ready_Es+%0d", tag, j), 32'(ready),
                  (j == 10 || j == 11) ? 32'd1 : 32'd0);
            check($sformatf("%s_ack_Es+%0d", tag, j), 32'(soft_ack), (j == 10) ? 32'd1 : 32'd0);
            check($sformatf("%s_cnt_Es+%0d", tag, j), 32'(cnt),
                  (j >= 10) ? 32'(base_cnt + 1) : 32'(base_cnt));
        end
    endtask

    initial begin
        reset_l   = 1'b0;
        soft_req  = 1'b0;
        reset_l1  = 1'b0;
        soft_req1 = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_sub", 32'(sub), 32'd0);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_ack", 32'(soft_ack), 32'd0);
        check("rst_cnt", 32'(cnt), 32'd0);
        check("rst_min_sub", 32'(sub1), 32'd0);

        // Power-on up to E9, then a sub-cycle reset glitch.
        @(negedge clk) reset_l = 1'b1;
        power_on_check("po1", 9);
        #2 reset_l = 1'b0;
        #1;
        check("glitch_sub", 32'(sub), 32'd0);
        check("glitch_ready", 32'(ready), 32'd0);
        check("glitch_cnt", 32'(cnt), 32'd0);
        @(negedge clk) reset_l = 1'b1;
        power_on_check("po2", 13);

        // Single soft sequence, request dropped right after Es.
        @(negedge clk) soft_req = 1'b1;
        soft_check("s1", 0, 0, 1);
        @(negedge clk) soft_req = 1'b0;
        soft_check("s1", 1, 11, 1);

        // Request held through power-on: ignored until RUN, then back-to-back sequences.
        @(negedge clk) begin
            reset_l  = 1'b0;
            soft_req = 1'b1;
        end
        @(posedge clk); #1;
        check("rst2_cnt", 32'(cnt), 32'd0);
        check("rst2_sub", 32'(sub), 32'd0);
        @(negedge clk) reset_l = 1'b1;
        power_on_check("po3", 13);
        soft_check("s2", 0, 12, 1);
        @(negedge clk) soft_req = 1'b0;
        soft_check("s3", 1, 11, 2);

        // Minimal config: sub at E4, ready at E5, then held request saturates the count.
        @(negedge clk) begin
            reset_l1  = 1'b1;
            soft_req1 = 1'b1;
        end
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            check($sformatf("min_sub_E%0d", k), 32'(sub1),
                  (k >= 4 && k != 6 && k != 10) ? 32'd1 : 32'd0);
            check($sformatf("min_ready_E%0d", k), 32'(ready1),
                  (k == 5 || k == 8 || k == 9) ? 32'd1 : 32'd0);
            check($sformatf("min_ack_E%0d", k), 32'(soft_ack1), (k == 8) ? 32'd1 : 32'd0);
            check($sformatf("min_cnt_E%0d", k), 32'(cnt1),
                  (k < 5) ? 32'd0 : ((k < 8) ? 32'd1 : 32'd2));
        end
        repeat (1200) @(posedge clk);
        @(negedge clk) soft_req1 = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("min_cnt_sat", 32'(cnt1), 32'd255);
        check("min_ready_end", 32'(ready1), 32'd1);
        check("min_sub_end", 32'(sub1), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
